// File: rtl/logicnet_lut_layer_prog.sv
// Runtime-programmable LogicNets neuron layer: per-neuron truth tables loaded
// through a config port, then evaluated on a ready/valid stream with one cycle of latency.
module logicnet_lut_layer_prog #(
   parameter int N_NEURONS = 4,
   parameter int ADDR_W    = 6,
   parameter int OUT_BITS  = 1,
   parameter int NW        = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cfg_we,
   input  logic [NW-1:0]                 cfg_neuron,
   input  logic [ADDR_W-1:0]             cfg_addr,
   input  logic [OUT_BITS-1:0]           cfg_data,
   input  logic                          cfg_done,
   input  logic                          cfg_start,
   output logic                          cfg_err,
   output logic                          cfg_mode,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [N_NEURONS*ADDR_W-1:0]   in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [N_NEURONS*OUT_BITS-1:0] out_data
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      ST_CFG   = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                          state_r;
   logic [OUT_BITS-1:0]             table_r [N_NEURONS][DEPTH];
   logic                            out_valid_r;
   logic [N_NEURONS*OUT_BITS-1:0]   out_data_r;
   logic                            cfg_err_r;

   logic                            neuron_ok_s;
   logic                            in_ready_s;
   logic                            fire_s;
   logic                            tbl_we_s;
   logic                            cfg_bad_s;
   logic [N_NEURONS*OUT_BITS-1:0]   lookup_s;

   // When the select width exactly covers the neuron count every index is legal.
   generate
      if ((1 << NW) == N_NEURONS) begin : g_full_sel
         assign neuron_ok_s = 1'b1;
      end else begin : g_partial_sel
         assign neuron_ok_s = (cfg_neuron < NW'(N_NEURONS));
      end
   endgenerate

   // Handshake, write qualification and per-neuron table lookup.
   always_comb begin
      in_ready_s = 1'b0;
      tbl_we_s   = 1'b0;
      cfg_bad_s  = 1'b0;
      lookup_s   = '0;
      if (state_r == ST_RUN) begin
         in_ready_s = !out_valid_r || out_ready;
      end else begin
         in_ready_s = 1'b0;
      end
      fire_s = in_valid && in_ready_s;
      if (cfg_we) begin
         if ((state_r == ST_CFG) && neuron_ok_s) begin
            tbl_we_s = 1'b1;
         end else begin
            cfg_bad_s = 1'b1;
         end
      end else begin
         tbl_we_s  = 1'b0;
         cfg_bad_s = 1'b0;
      end
      for (int k = 0; k < N_NEURONS; k++) begin
         lookup_s[k*OUT_BITS +: OUT_BITS] = table_r[k][in_data[k*ADDR_W +: ADDR_W]];
      end
   end

   // Truth-table storage; only written in CFG, so it never changes under a lookup.
   always_ff @(posedge clk) begin
      if (rst) begin
         table_r <= '{default: '0};
      end else if (tbl_we_s) begin
         table_r[cfg_neuron][cfg_addr] <= cfg_data;
      end
   end

   // Mode sequencing: CFG -> RUN -> DRAIN -> CFG.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_CFG;
      end else begin
         case (state_r)
            ST_CFG: begin
               if (cfg_done) state_r <= ST_RUN;
            end
            ST_RUN: begin
               if (cfg_start) state_r <= ST_DRAIN;
            end
            ST_DRAIN: begin
               // Leave once nothing is held or the held word is leaving now.
               if (!out_valid_r || out_ready) state_r <= ST_CFG;
            end
            default: state_r <= ST_CFG;
         endcase
      end
   end

   // Output register: load on accept, hold under backpressure, drop valid on drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
      end else if (fire_s) begin
         out_valid_r <= 1'b1;
         out_data_r  <= lookup_s;
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   // Sticky configuration error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_err_r <= 1'b0;
      end else if (cfg_bad_s) begin
         cfg_err_r <= 1'b1;
      end
   end

   assign cfg_err   = cfg_err_r;
   assign cfg_mode  = (state_r == ST_CFG);
   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;

endmodule

// File: tb/tb_logicnet_lut_layer_prog.sv
// Directed/randomized bench for logicnet_lut_layer_prog; expected outputs come from a
// table-array reference model updated only when a write is supposed to land.
module tb_logicnet_lut_layer_prog;

   localparam int N  = 3;
   localparam int AW = 6;
   localparam int OB = 1;
   localparam int NW = 2;
   localparam int DW = N * AW;
   localparam int OW = N * OB;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_we;
   logic [NW-1:0] cfg_neuron;
   logic [AW-1:0] cfg_addr;
   logic [OB-1:0] cfg_data;
   logic          cfg_done;
   logic          cfg_start;
   logic          cfg_err;
   logic          cfg_mode;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_data;

   int tests = 0;
   int fails = 0;
   logic [OB-1:0] mdl [N][64];

   always #5 clk = ~clk;

   logicnet_lut_layer_prog #(.N_NEURONS(N), .ADDR_W(AW), .OUT_BITS(OB), .NW(NW)) dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_neuron(cfg_neuron), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .cfg_done(cfg_done), .cfg_start(cfg_start), .cfg_err(cfg_err), .cfg_mode(cfg_mode),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [OW-1:0] ref_out(input logic [DW-1:0] w);
      logic [OW-1:0] r;
      r = '0;
      for (int k = 0; k < N; k++) r[k*OB +: OB] = mdl[k][w[k*AW +: AW]];
      return r;
   endfunction

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int k = 0; k < N; k++) w[k*AW +: AW] = AW'($urandom_range(0, 63));
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [DW-1:0] w;
      logic [OW-1:0] exp_o;
      logic [OB-1:0] v;

      rst = 1'b1; cfg_we = 1'b0; cfg_neuron = '0; cfg_addr = '0; cfg_data = '0;
      cfg_done = 1'b0; cfg_start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      for (int k = 0; k < N; k++) for (int a = 0; a < 64; a++) mdl[k][a] = '0;
      tick(); tick();
      rst = 1'b0;
      #1;
      check("rst_cfg_mode", 64'(cfg_mode), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_cfg_err", 64'(cfg_err), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);

      // Load: neuron0 = (addr<6), neuron1 = parity(addr), neuron2 random; last write with cfg_done
      for (int k = 0; k < N; k++) begin
         for (int a = 0; a < 64; a++) begin
            if (k == 0) v = OB'(a < 6);
            else if (k == 1) v = OB'($countones(a) % 2);
            else v = OB'($urandom_range(0, 1));
            cfg_we = 1'b1; cfg_neuron = NW'(k); cfg_addr = AW'(a); cfg_data = v;
            cfg_done = (k == N-1) && (a == 63);
            tick();
            mdl[k][a] = v;
         end
      end
      cfg_we = 1'b0; cfg_done = 1'b0;
      check("load_cfg_mode", 64'(cfg_mode), 64'd0);
      check("load_cfg_err", 64'(cfg_err), 64'd0);

      // Test 1: neuron0=3, neuron1=7
      w = rand_word();
      w[AW-1:0] = 6'd3; w[2*AW-1:AW] = 6'd7;
      in_data = w; in_valid = 1'b1; out_ready = 1'b1;
      #1 check("t1_in_ready", 64'(in_ready), 64'd1);
      tick();
      check("t1_out_valid", 64'(out_valid), 64'd1);
      check("t1_bits01", 64'(out_data[1:0]), 64'd3);
      check("t1_out_data", 64'(out_data), 64'(ref_out(w)));

      // Test 2: 64 back-to-back words, no bubbles (last one is the entry with addr 63)
      for (int i = 0; i < 64; i++) begin
         w = rand_word();
         w[AW-1:0] = AW'(i);
         in_data = w; in_valid = 1'b1; out_ready = 1'b1;
         #1 check("t2_in_ready", 64'(in_ready), 64'd1);
         tick();
         check("t2_out_valid", 64'(out_valid), 64'd1);
         check("t2_out_data", 64'(out_data), 64'(ref_out(w)));
      end
      exp_o = ref_out(w);

      // Test 3: backpressure for 5 cycles, then accept on the release cycle
      w = rand_word();
      in_data = w; in_valid = 1'b1; out_ready = 1'b0;
      #1 check("t3_in_ready_low", 64'(in_ready), 64'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t3_hold_valid", 64'(out_valid), 64'd1);
         check("t3_hold_data", 64'(out_data), 64'(exp_o));
         check("t3_hold_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      #1 check("t3_release_ready", 64'(in_ready), 64'd1);
      tick();
      check("t3_new_valid", 64'(out_valid), 64'd1);
      check("t3_new_data", 64'(out_data), 64'(ref_out(w)));
      exp_o = ref_out(w);
      in_valid = 1'b0;
      tick();
      check("t3_drain_valid", 64'(out_valid), 64'd0);
      check("t3_keep_data", 64'(out_data), 64'(exp_o));

      // Test 4: write during RUN is ignored and flags an error
      cfg_we = 1'b1; cfg_neuron = 2'd0; cfg_addr = 6'd10; cfg_data = 1'b1;
      tick();
      cfg_we = 1'b0;
      check("t4_cfg_err", 64'(cfg_err), 64'd1);
      w = rand_word();
      w[AW-1:0] = 6'd10;
      in_data = w; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("t4_entry_unchanged", 64'(out_data[0]), 64'd0);
      check("t4_out_data", 64'(out_data), 64'(ref_out(w)));
      tick();
      check("t4_err_sticky", 64'(cfg_err), 64'd1);

      // Test 5: drain with a pending word, reprogram one entry
      w = rand_word();
      in_data = w; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      exp_o = ref_out(w);
      check("t5_pending", 64'(out_valid), 64'd1);
      in_valid = 1'b0; cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      in_valid = 1'b1; in_data = rand_word();
      #1;
      check("t5_drain_ready", 64'(in_ready), 64'd0);
      check("t5_drain_mode", 64'(cfg_mode), 64'd0);
      tick();
      check("t5_drain_hold_valid", 64'(out_valid), 64'd1);
      check("t5_drain_hold_data", 64'(out_data), 64'(exp_o));
      out_ready = 1'b1; in_valid = 1'b0;
      tick();
      check("t5_delivered", 64'(out_valid), 64'd0);
      check("t5_cfg_mode", 64'(cfg_mode), 64'd1);
      cfg_we = 1'b1; cfg_neuron = 2'd0; cfg_addr = 6'd10; cfg_data = 1'b1; cfg_done = 1'b1;
      tick();
      mdl[0][10] = 1'b1;
      cfg_we = 1'b0; cfg_done = 1'b0;
      check("t5_run_again", 64'(cfg_mode), 64'd0);
      w = rand_word();
      w[AW-1:0] = 6'd10;
      in_data = w; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("t5_new_entry", 64'(out_data[0]), 64'd1);
      check("t5_out_data", 64'(out_data), 64'(ref_out(w)));

      // Test 6: reset mid-stream clears output, state and tables
      in_data = rand_word(); in_valid = 1'b1; out_ready = 1'b0;
      tick();
      check("t6_pending", 64'(out_valid), 64'd1);
      rst = 1'b1; in_valid = 1'b0;
      tick();
      rst = 1'b0;
      for (int k = 0; k < N; k++) for (int a = 0; a < 64; a++) mdl[k][a] = '0;
      check("t6_out_valid", 64'(out_valid), 64'd0);
      check("t6_cfg_mode", 64'(cfg_mode), 64'd1);
      check("t6_out_data", 64'(out_data), 64'd0);
      check("t6_cfg_err", 64'(cfg_err), 64'd0);
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      check("t6_start_in_cfg", 64'(cfg_mode), 64'd1);
      check("t6_start_no_err", 64'(cfg_err), 64'd0);
      cfg_we = 1'b1; cfg_neuron = 2'd3; cfg_addr = 6'd5; cfg_data = 1'b1;
      tick();
      cfg_we = 1'b0;
      check("t6_bad_neuron_err", 64'(cfg_err), 64'd1);
      cfg_done = 1'b1;
      tick();
      cfg_done = 1'b0;
      check("t6_run", 64'(cfg_mode), 64'd0);
      for (int i = 0; i < 8; i++) begin
         w = rand_word();
         if (i == 0) w[AW-1:0] = 6'd5;
         in_data = w; in_valid = 1'b1; out_ready = 1'b1;
         tick();
         check("t6_zero_lookup", 64'(out_data), 64'(ref_out(w)));
      end
      in_valid = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
